traffic_phase_sequencer: RTL
============================

Name: traffic_phase_sequencer

Overview:
- Upstream stage of the traffic-light control unit; generates its request code `sw_traffic_lights` and pedestrian pulse `btn`.
- Watches the control unit's one-hot light word `cw_traffic_lights` and times each phase with a clock prescaler and per-phase tick limits.
- Debounces a raw pedestrian button and issues a single-cycle `btn` during Green once a minimum green time has elapsed.

Parameters:
- PRESCALE, 1000, clk cycles per tick (>=2).
- RED_TICKS, 10, ticks in Red before requesting Green (1..255).
- GREEN_TICKS, 10, ticks in Green before requesting Yellow (1..255).
- YELLOW_TICKS, 3, ticks in Yellow before requesting Red (1..255).
- MIN_GREEN_TICKS, 4, minimum Green ticks before a pedestrian `btn` may issue (0..GREEN_TICKS-1).
- DEBOUNCE, 16, consecutive stable clk cycles required to accept a button level change (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ped_raw  input  1  raw pedestrian button, asynchronous, active high.
- cw_traffic_lights  input  3  current light from control unit: 100 Red, 010 Green, 001 Yellow; any other value means no phase.
- sw_traffic_lights  output  2  registered phase request: 00 none, 01 Red, 10 Green, 11 Yellow.
- btn  output  1  registered single-cycle pedestrian request.

Behaviour:
- Reset (async assert, sync-release use): sw_traffic_lights=00, btn=0, cw_q=000, tick_cnt=0, prescale_cnt=0, sync FFs=0, db_state=0, db_cnt=0, ped_pending=0.
- Phase decode from cw: 100 RED, 010 GREEN, 001 YELLOW; all other codes NONE.
- Phase change: cw_q registers cw every cycle. On an edge where cw != cw_q (call it E0):
  - tick_cnt<=0, prescale_cnt<=0, sw<=00, btn<=0.
  - Timing restarts deterministically at E0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is high when prescale_cnt==PRESCALE-1.
  - Runs only in RED/GREEN/YELLOW; held at 0 in NONE.
- Phase timer (8-bit tick_cnt):
  - Increments on tick while the phase is valid and sw==00.
  - On the tick where tick_cnt==LIMIT-1: tick_cnt<=LIMIT (saturates) and sw<=request.
  - Requests: RED→10, GREEN→11, YELLOW→01.
  - sw first becomes visible after edge E0+LIMIT*PRESCALE.
  - sw is held until the next phase change.
  - In NONE: sw=00 and tick_cnt=0.
- Button path:
  - ped_raw passes through a 2-FF synchronizer to ped_s.
  - db_cnt increments while ped_s!=db_state and clears when they are equal.
  - When db_cnt reaches DEBOUNCE-1 with ped_s still different, db_state<=ped_s and db_cnt<=0.
  - A db_state 0→1 transition sets ped_pending. Pending presses made in Red, Yellow or NONE are kept until Green.
  - Holding the button produces one press; it must be released (debounced) before another press registers.
- btn issue:
  - Condition: phase GREEN, ped_pending=1, sw==00, tick_cnt>=MIN_GREEN_TICKS, no phase change on this edge.
  - Result: btn<=1 for exactly one cycle and ped_pending<=0.
  - btn is never high on two consecutive cycles.
- Simultaneous events:
  - Green timeout tick and btn eligible on the same edge: sw<=11 wins, btn stays 0, ped_pending is cleared (yellow is already coming).
  - New press on the same edge as btn issue: ped_pending is set, so the new press is kept.
  - Phase change on the same edge as the timeout tick: the phase change wins, counters clear and sw=00.
- Reset mid-operation: all state returns to reset values immediately, including a pending press and an in-flight debounce.

Test Plan:
Bench parameters: PRESCALE=4, RED_TICKS=3, GREEN_TICKS=5, YELLOW_TICKS=2, MIN_GREEN_TICKS=2, DEBOUNCE=3. Clock is free-running.
- Reset: assert reset_n=0 mid-count with sw=10 → sw=00, btn=0 asynchronously. Release, drive cw=000 for 20 cycles → sw stays 00 and btn never pulses.
- Red timing: cw 000→100 (E0) → sw=00 through edge E0+11, sw=10 after edge E0+12, held while cw=100.
- Full cycle with no pedestrian, cw driven by a model of the control unit:
  - Green: sw=11 at E0+20.
  - Yellow: sw=01 at E0+8.
  - Each phase change clears sw to 00 on its E0.
- Pedestrian in Green:
  - Enter Green. Press ped_raw for 6 cycles starting at E0+1; the press is accepted ~5 cycles later.
  - btn waits until tick_cnt=2, then pulses at edge E0+8 (after debounce, at the first eligible edge) for exactly one cycle.
  - sw stays 00. The model cw then goes 010→000→001.
- Pending from Red: press and release during Red → no btn in Red or Yellow. In the next Green, btn pulses once at E0+8.
- Bounce/edge cases:
  - Toggle ped_raw every 2 cycles for 20 cycles → no press accepted.
  - Press arriving with tick_cnt=4 so acceptance coincides with the Green timeout tick → sw=11, btn=0, ped_pending cleared.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Purpose : times each traffic-light phase and issues the phase-request code and
//           debounced pedestrian pulse to the control unit.
// Latency : outputs registered; sw appears one edge after the final phase tick.
//           btn follows the debounced press by at least one edge.
// Backpressure: none. Requests are held until the light word changes.
//           Pedestrian presses wait in a one-deep pending flag until Green.
// Ports   : clk, reset_n (async active-low)
//           ped_raw (async button)
//           cw_traffic_lights (one-hot light: 100 R, 010 G, 001 Y)
//           sw_traffic_lights (00 none, 01 R, 10 G, 11 Y)
//           btn (one-cycle pedestrian request)
module traffic_phase_sequencer #(
    parameter int unsigned PRESCALE        = 1000,
    parameter int unsigned RED_TICKS       = 10,
    parameter int unsigned GREEN_TICKS     = 10,
    parameter int unsigned YELLOW_TICKS    = 3,
    parameter int unsigned MIN_GREEN_TICKS = 4,
    parameter int unsigned DEBOUNCE        = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ped_raw,
    input  logic [2:0] cw_traffic_lights,
    output logic [1:0] sw_traffic_lights,
    output logic       btn
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_e;

    // State
    logic [2:0]    cw_q;
    logic [PW-1:0] prescale_cnt_q, prescale_cnt_d;
    logic [7:0]    tick_cnt_q, tick_cnt_d;
    logic [1:0]    sw_q, sw_d;
    logic          btn_q, btn_d;
    logic          sync1_q, sync2_q;
    logic          db_state_q, db_state_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          ped_pending_q, ped_pending_d;

    // Decoded phase and per-phase constants
    phase_e     phase;
    logic       phase_vld;
    logic       phase_chg;
    logic       tick;
    logic       timeout;
    logic       db_rise;
    logic       btn_ok;
    logic [7:0] limit;
    logic [1:0] req;

    always_comb begin
        phase = PH_NONE;
        case (cw_traffic_lights)
            3'b100:  phase = PH_RED;
            3'b010:  phase = PH_GREEN;
            3'b001:  phase = PH_YELLOW;
            default: phase = PH_NONE;
        endcase
    end

    always_comb begin
        limit = 8'd1;
        req   = 2'b00;
        case (phase)
            PH_RED: begin
                limit = 8'(RED_TICKS);
                req   = 2'b10;
            end
            PH_GREEN: begin
                limit = 8'(GREEN_TICKS);
                req   = 2'b11;
            end
            PH_YELLOW: begin
                limit = 8'(YELLOW_TICKS);
                req   = 2'b01;
            end
            default: begin
                limit = 8'd1;
                req   = 2'b00;
            end
        endcase
    end

    assign phase_vld = (phase != PH_NONE);
    assign phase_chg = (cw_traffic_lights != cw_q);
    assign tick      = phase_vld && (prescale_cnt_q == PW'(PRESCALE - 1));
    // A phase change on the same edge overrides the timeout.
    assign timeout   = tick && !phase_chg && (sw_q == 2'b00) &&
                       (tick_cnt_q == (limit - 8'd1));

    // Prescaler, phase timer and request register
    always_comb begin
        prescale_cnt_d = prescale_cnt_q;
        tick_cnt_d     = tick_cnt_q;
        sw_d           = sw_q;
        if (phase_chg || !phase_vld) begin
            prescale_cnt_d = '0;
            tick_cnt_d     = 8'd0;
            sw_d           = 2'b00;
        end else begin
            prescale_cnt_d = tick ? '0 : prescale_cnt_q + 1'b1;
            if (tick && (sw_q == 2'b00)) begin
                if (timeout) begin
                    tick_cnt_d = limit;
                    sw_d       = req;
                end else begin
                    tick_cnt_d = tick_cnt_q + 8'd1;
                end
            end
        end
    end

    // Debouncer on the synchronised button level
    always_comb begin
        db_state_d = db_state_q;
        db_cnt_d   = '0;
        if (sync2_q != db_state_q) begin
            if (db_cnt_q == DW'(DEBOUNCE - 1)) begin
                db_state_d = sync2_q;
                db_cnt_d   = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign db_rise = !db_state_q && db_state_d;

    // btn uses the tick count as it will be after this edge, so the pulse lands
    // on the same edge the minimum green time is reached. The !btn_q term keeps
    // a press accepted on the issue edge from producing back-to-back pulses.
    assign btn_ok = (phase == PH_GREEN) && ped_pending_q && (sw_q == 2'b00) &&
                    (tick_cnt_d >= 8'(MIN_GREEN_TICKS)) && !phase_chg &&
                    !timeout && !btn_q;

    always_comb begin
        btn_d         = btn_ok;
        ped_pending_d = ped_pending_q | db_rise;
        if (timeout && (phase == PH_GREEN)) begin
            // Yellow is already being requested; any press is moot.
            ped_pending_d = 1'b0;
        end else if (btn_ok) begin
            ped_pending_d = db_rise;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cw_q           <= 3'b000;
            prescale_cnt_q <= '0;
            tick_cnt_q     <= 8'd0;
            sw_q           <= 2'b00;
            btn_q          <= 1'b0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            db_state_q     <= 1'b0;
            db_cnt_q       <= '0;
            ped_pending_q  <= 1'b0;
        end else begin
            cw_q           <= cw_traffic_lights;
            prescale_cnt_q <= prescale_cnt_d;
            tick_cnt_q     <= tick_cnt_d;
            sw_q           <= sw_d;
            btn_q          <= btn_d;
            sync1_q        <= ped_raw;
            sync2_q        <= sync1_q;
            db_state_q     <= db_state_d;
            db_cnt_q       <= db_cnt_d;
            ped_pending_q  <= ped_pending_d;
        end
    end

    assign sw_traffic_lights = sw_q;
    assign btn               = btn_q;

endmodule
